// File: rtl/multdiv_pkg.sv
// Shared op-code encoding, FSM state type and op-class helpers for the E-stage
// multiply/divide unit and the decoder that drives it.
package multdiv_pkg;

  localparam logic [3:0] NONE  = 4'd0;
  localparam logic [3:0] MULT  = 4'd1;
  localparam logic [3:0] MULTU = 4'd2;
  localparam logic [3:0] DIV   = 4'd3;
  localparam logic [3:0] DIVU  = 4'd4;
  localparam logic [3:0] MTHI  = 4'd5;
  localparam logic [3:0] MTLO  = 4'd6;
  localparam logic [3:0] MADD  = 4'd7;
  localparam logic [3:0] MADDU = 4'd8;
  localparam logic [3:0] MSUB  = 4'd9;
  localparam logic [3:0] MSUBU = 4'd10;

  typedef enum logic {IDLE, RUN} state_t;

  function automatic logic is_mul(input logic [3:0] op_i);
    return (op_i == MULT) || (op_i == MULTU) || (op_i == MADD) ||
           (op_i == MADDU) || (op_i == MSUB) || (op_i == MSUBU);
  endfunction

  function automatic logic is_div(input logic [3:0] op_i);
    return (op_i == DIV) || (op_i == DIVU);
  endfunction

endpackage

// File: rtl/multdiv_unit_md_counter.sv
// Loadable down-counter; tc_o flags the last busy cycle (count == 1).
module md_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          dec_i,
  output logic [CW-1:0] count_o,
  output logic          tc_o
);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i) begin
      count_q <= count_q - CW'(1);
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == CW'(1));

endmodule

// File: rtl/multdiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO. The result is computed when the
// op is captured and held until the counter expires, so cancel simply drops it.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     hi_q, lo_q;
  logic [2*WIDTH-1:0]   res_q, res_d;
  logic                 capture, commit, wr_hi, wr_lo;
  logic                 cnt_load, cnt_dec, cnt_tc;
  logic [CW-1:0]        cnt_val, cnt_count;

  logic                 mul_signed, div_signed, a_neg, b_neg;
  logic [2*WIDTH-1:0]   a_ext, b_ext, prod, acc;
  logic [WIDTH-1:0]     a_mag, b_mag, uq, ur, q, r;

  md_counter #(.CW(CW)) u_counter (
    .clk       (clk),
    .reset     (reset),
    .load_i    (cnt_load),
    .load_val_i(cnt_val),
    .dec_i     (cnt_dec),
    .count_o   (cnt_count),
    .tc_o      (cnt_tc)
  );

  always_comb begin
    mul_signed = (op == MULT) || (op == MADD) || (op == MSUB);
    a_ext = mul_signed ? {{WIDTH{rs[WIDTH-1]}}, rs} : {{WIDTH{1'b0}}, rs};
    b_ext = mul_signed ? {{WIDTH{rt[WIDTH-1]}}, rt} : {{WIDTH{1'b0}}, rt};
    prod  = a_ext * b_ext;
    acc   = {hi_q, lo_q};

    // Signed divide via magnitudes; MIN/-1 wraps back to MIN with remainder 0.
    div_signed = (op == DIV);
    a_neg = div_signed && rs[WIDTH-1];
    b_neg = div_signed && rt[WIDTH-1];
    a_mag = a_neg ? -rs : rs;
    b_mag = b_neg ? -rt : rt;
    uq    = a_mag / b_mag;
    ur    = a_mag % b_mag;
    q     = (a_neg ^ b_neg) ? -uq : uq;
    r     = a_neg ? -ur : ur;
    if (rt == '0) begin
      q = '1;
      r = rs;
    end

    res_d = prod;
    case (op)
      MADD, MADDU: res_d = acc + prod;
      MSUB, MSUBU: res_d = acc - prod;
      DIV, DIVU:   res_d = {r, q};
      default:     res_d = prod;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    commit   = 1'b0;
    wr_hi    = 1'b0;
    wr_lo    = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !cancel) begin
          if (is_mul(op) || is_div(op)) begin
            capture  = 1'b1;
            cnt_load = 1'b1;
            cnt_val  = is_mul(op) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            state_d  = RUN;
          end else begin
            wr_hi = (op == MTHI);
            wr_lo = (op == MTLO);
          end
        end
      end
      RUN: begin
        // Terminal count wins over a same-edge cancel: the result commits.
        if (cnt_tc) begin
          commit  = 1'b1;
          cnt_dec = 1'b1;
          state_d = IDLE;
        end else if (cancel) begin
          cnt_load = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      res_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      if (capture) res_q <= res_d;
      if (commit) begin
        {hi_q, lo_q} <= res_q;
      end else begin
        if (wr_hi) hi_q <= rs;
        if (wr_lo) lo_q <= rs;
      end
    end
  end

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit: default 32-bit instance plus a 16-bit, 1/3-cycle one.
module tb_multdiv_unit;
  import multdiv_pkg::*;

  logic        clk, reset;
  logic        start, cancel;
  logic [3:0]  op;
  logic [31:0] rs, rt, hi, lo;
  logic        busy;

  logic        s_start, s_cancel, s_busy;
  logic [3:0]  s_op;
  logic [15:0] s_rs, s_rt, s_hi, s_lo;

  int checks = 0;
  int errors = 0;

  multdiv_unit u_dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
    .cancel(cancel), .busy(busy), .hi(hi), .lo(lo)
  );

  multdiv_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) u_dut16 (
    .clk(clk), .reset(reset), .start(s_start), .op(s_op), .rs(s_rs), .rt(s_rt),
    .cancel(s_cancel), .busy(s_busy), .hi(s_hi), .lo(s_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset) begin
      assert (!(start && busy)) else $error("start issued while busy (32-bit)");
      assert (!(s_start && s_busy)) else $error("start issued while busy (16-bit)");
    end
  end

  // Issue one op at the current negedge, then count cycles until busy drops.
  task automatic run32(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int cyc, output logic [31:0] hold_hi, output logic [31:0] hold_lo);
    start = 1'b1; op = o; rs = a; rt = b;
    @(negedge clk);
    start = 1'b0; op = NONE;
    hold_hi = hi; hold_lo = lo;
    cyc = 0;
    while (busy && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    $display("op32 %0d rs=%h rt=%h -> hi=%h lo=%h busy_cycles=%0d", o, a, b, hi, lo, cyc);
  endtask

  task automatic run16(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                       output int cyc);
    s_start = 1'b1; s_op = o; s_rs = a; s_rt = b;
    @(negedge clk);
    s_start = 1'b0; s_op = NONE;
    cyc = 0;
    while (s_busy && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    $display("op16 %0d rs=%h rt=%h -> hi=%h lo=%h busy_cycles=%0d", o, a, b, s_hi, s_lo, cyc);
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, hi, lo} !== 65'd0) begin
      errors++; $display("FAIL reset_in: got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, hi, lo, s_busy, s_hi, s_lo} !== 98'd0) begin
      errors++; $display("FAIL reset_out: got busy=%b hi=%h lo=%h s_busy=%b s_hi=%h s_lo=%h want 0",
                         busy, hi, lo, s_busy, s_hi, s_lo);
    end
  endtask

  task automatic test_mul();
    int c; logic [31:0] hh, hl;
    run32(MULT, 32'hFFFF_FFFF, 32'h0000_0003, c, hh, hl);
    checks++;
    if (c !== 5) begin errors++; $display("FAIL mult_busy: got %0d want 5", c); end
    checks++;
    if ({hh, hl} !== 64'd0) begin errors++; $display("FAIL mult_hold: got %h want 0", {hh, hl}); end
    checks++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      errors++; $display("FAIL mult_res: got %h_%h want FFFFFFFF_FFFFFFFD", hi, lo);
    end
    run32(MULTU, 32'hFFFF_FFFF, 32'h0000_0003, c, hh, hl);
    checks++;
    if ({hi, lo} !== 64'h0000_0002_FFFF_FFFD || c !== 5) begin
      errors++; $display("FAIL multu_res: got %h_%h cyc=%0d want 00000002_FFFFFFFD cyc=5", hi, lo, c);
    end
  endtask

  task automatic test_div();
    int c; logic [31:0] hh, hl;
    run32(DIVU, 32'd7, 32'd2, c, hh, hl);
    checks++;
    if (c !== 10 || lo !== 32'd3 || hi !== 32'd1) begin
      errors++; $display("FAIL divu: got cyc=%0d hi=%h lo=%h want 10/1/3", c, hi, lo);
    end
    run32(DIV, 32'hFFFF_FFF9, 32'd2, c, hh, hl);
    checks++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL div_neg: got hi=%h lo=%h want FFFFFFFF/FFFFFFFD", hi, lo);
    end
    run32(DIV, 32'd5, 32'd0, c, hh, hl);
    checks++;
    if (lo !== 32'hFFFF_FFFF || hi !== 32'd5) begin
      errors++; $display("FAIL div_zero: got hi=%h lo=%h want 00000005/FFFFFFFF", hi, lo);
    end
    run32(DIV, 32'h8000_0000, 32'hFFFF_FFFF, c, hh, hl);
    checks++;
    if (lo !== 32'h8000_0000 || hi !== 32'd0) begin
      errors++; $display("FAIL div_ovf: got hi=%h lo=%h want 00000000/80000000", hi, lo);
    end
  endtask

  task automatic test_mac();
    int c; logic [31:0] hh, hl;
    run32(MTHI, 32'd0, 32'd0, c, hh, hl);
    run32(MTLO, 32'hFFFF_FFFF, 32'd0, c, hh, hl);
    checks++;
    if (c !== 0 || hi !== 32'd0 || lo !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL mtlo: got cyc=%0d hi=%h lo=%h want 0/00000000/FFFFFFFF", c, hi, lo);
    end
    run32(MADDU, 32'd1, 32'd1, c, hh, hl);
    checks++;
    if (c !== 5 || hi !== 32'd1 || lo !== 32'd0) begin
      errors++; $display("FAIL maddu: got cyc=%0d hi=%h lo=%h want 5/1/0", c, hi, lo);
    end
    run32(MSUB, 32'd1, 32'd2, c, hh, hl);
    checks++;
    if (hi !== 32'd0 || lo !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL msub: got hi=%h lo=%h want 00000000/FFFFFFFE", hi, lo);
    end
  endtask

  task automatic test_cancel();
    int c; logic [31:0] hh, hl;
    run32(MTHI, 32'h0000_000A, 32'd0, c, hh, hl);
    run32(MTLO, 32'h0000_000B, 32'd0, c, hh, hl);
    start = 1'b1; op = DIV; rs = 32'd100; rt = 32'd3;
    @(negedge clk);
    start = 1'b0; op = NONE;
    repeat (3) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    $display("cancel DIV at cycle 4 -> busy=%b hi=%h lo=%h", busy, hi, lo);
    checks++;
    if (busy !== 1'b0 || hi !== 32'hA || lo !== 32'hB) begin
      errors++; $display("FAIL cancel_run: got busy=%b hi=%h lo=%h want 0/A/B", busy, hi, lo);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (hi !== 32'hA || lo !== 32'hB) begin
      errors++; $display("FAIL cancel_nowrite: got hi=%h lo=%h want A/B", hi, lo);
    end
    start = 1'b1; op = MTLO; rs = 32'h1234_5678; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; op = NONE; cancel = 1'b0;
    $display("cancel MTLO same cycle -> lo=%h", lo);
    checks++;
    if (lo !== 32'hB) begin errors++; $display("FAIL cancel_mtlo: got lo=%h want B", lo); end
    start = 1'b1; op = DIV; rs = 32'd9; rt = 32'd2; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; op = NONE; cancel = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL cancel_start: got busy=%b want 0", busy); end
    // Cancel landing on the terminal edge is too late.
    start = 1'b1; op = MULT; rs = 32'd2; rt = 32'd3;
    @(negedge clk);
    start = 1'b0; op = NONE;
    repeat (4) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    $display("late cancel MULT -> busy=%b hi=%h lo=%h", busy, hi, lo);
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd6) begin
      errors++; $display("FAIL cancel_late: got busy=%b hi=%h lo=%h want 0/0/6", busy, hi, lo);
    end
  endtask

  task automatic test_reset_mid();
    int c; logic [31:0] hh, hl;
    run32(MTHI, 32'h5555_5555, 32'd0, c, hh, hl);
    start = 1'b1; op = MULT; rs = 32'd6; rt = 32'd7;
    @(negedge clk);
    start = 1'b0; op = NONE;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    $display("reset mid-MULT -> busy=%b hi=%h lo=%h", busy, hi, lo);
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL reset_mid: got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run32(MULT, 32'd6, 32'd7, c, hh, hl);
    checks++;
    if (c !== 5 || hi !== 32'd0 || lo !== 32'h2A) begin
      errors++; $display("FAIL reset_recover: got cyc=%0d hi=%h lo=%h want 5/0/2A", c, hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int c;
    run16(MULT, 16'h8000, 16'h8000, c);
    checks++;
    if (c !== 1 || s_hi !== 16'h4000 || s_lo !== 16'h0000) begin
      errors++; $display("FAIL p16_mult: got cyc=%0d hi=%h lo=%h want 1/4000/0000", c, s_hi, s_lo);
    end
    run16(MULTU, 16'h0003, 16'h0005, c);
    checks++;
    if (c !== 1 || s_hi !== 16'h0000 || s_lo !== 16'h000F) begin
      errors++; $display("FAIL p16_b2b: got cyc=%0d hi=%h lo=%h want 1/0000/000F", c, s_hi, s_lo);
    end
    run16(DIV, 16'hFFF9, 16'h0002, c);
    checks++;
    if (c !== 3 || s_hi !== 16'hFFFF || s_lo !== 16'hFFFD) begin
      errors++; $display("FAIL p16_div: got cyc=%0d hi=%h lo=%h want 3/FFFF/FFFD", c, s_hi, s_lo);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; cancel = 1'b0; op = NONE; rs = '0; rt = '0;
    s_start = 1'b0; s_cancel = 1'b0; s_op = NONE; s_rs = '0; s_rt = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_mul();
    test_div();
    test_mac();
    test_cancel();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
